cosmac_mem_arbiter: RTL

Bus-cycle sequencer and arbiter between the COSMAC (CDP1802) external bus and the chip's single-port internal RAM. Synchronises the asynchronous CPU strobes (TPA, TPB, /MRD, /MWR) into the fabric clock and rebuilds the 16-bit address from the multiplexed MA lines. Issues RAM reads and writes on the CPU's behalf and drives the DB output enable. Grants idle RAM slots to a secondary host port (loader/debug) without corrupting CPU cycles.

---
 rtl/cosmac_mem_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cosmac_mem_arbiter.sv
// CDP1802 bus-cycle sequencer: arbitrates the single-port internal RAM between the CPU bus and a host port.
// Optional feature macro: COSMEM_WAIT_EN (drives CPU /WAIT while a CPU read is held off by host traffic).
module cosmac_mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [15:0] BASE   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tpa,
  input  logic              tpb,
  input  logic              nmrd,
  input  logic              nmwr,
  input  logic [7:0]        ma,
  input  logic [7:0]        db_in,
  output logic [7:0]        db_out,
  output logic              db_oe,
  output logic              nwait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CPU_RD      = 3'd1,
    CPU_RD_HOLD = 3'd2,
    CPU_WR_WAIT = 3'd3,
    CPU_WR      = 3'd4,
    HOST_ACC    = 3'd5,
    HOST_DONE   = 3'd6
  } state_t;

  // Strobe bit order {nmwr, nmrd, tpb, tpa}; reset to bus-idle levels so no false edge follows reset.
  localparam logic [3:0] STROBE_IDLE = 4'b1100;

  state_t      state_r;
  logic [3:0]  meta_r;
  logic [3:0]  sync_r;
  logic [3:0]  prev_r;
  logic [7:0]  addr_hi_r;
  logic [7:0]  addr_lo_r;
  logic        rd_pend_r;
  logic        wr_pend_r;
  logic        acc_we_r;

  logic        tpa_fall_s;
  logic        tpb_rise_s;
  logic        mrd_fall_s;
  logic        mwr_fall_s;
  logic        nmrd_s;
  logic        nmwr_s;
  logic [7:0]  addr_lo_s;
  logic [15:0] addr_s;
  logic        hit_s;
  logic        rd_evt_s;
  logic        wr_evt_s;
  logic        rd_go_s;
  logic        wr_go_s;
  logic        host_busy_s;

  assign tpa_fall_s  = prev_r[0] & ~sync_r[0];
  assign tpb_rise_s  = ~prev_r[1] & sync_r[1];
  assign mrd_fall_s  = prev_r[2] & ~sync_r[2];
  assign mwr_fall_s  = prev_r[3] & ~sync_r[3];
  assign nmrd_s      = sync_r[2];
  assign nmwr_s      = sync_r[3];

  // The low byte is taken straight from MA on the strobe edge so hit and RAM address are valid that same clock.
  assign addr_lo_s   = (mrd_fall_s | mwr_fall_s) ? ma : addr_lo_r;
  assign addr_s      = {addr_hi_r, addr_lo_s};
  assign hit_s       = (addr_s[15:ADDR_W] == BASE[15:ADDR_W]);

  // Simultaneous /MRD and /MWR falls resolve to a read.
  assign rd_evt_s    = mrd_fall_s & hit_s;
  assign wr_evt_s    = mwr_fall_s & ~mrd_fall_s & hit_s;
  assign rd_go_s     = rd_evt_s | rd_pend_r;
  assign wr_go_s     = ~rd_go_s & (wr_evt_s | wr_pend_r);
  assign host_busy_s = (state_r == HOST_ACC) || (state_r == HOST_DONE);

`ifdef COSMEM_WAIT_EN
  logic host_req_prev_r;
  logic rd_open_s;

  // A CPU read is open while it is pending or in flight but its data is not yet on the bus.
  assign rd_open_s = rd_pend_r || (state_r == CPU_RD) || ((state_r == CPU_RD_HOLD) && !db_oe);
`endif

  // Two-flop synchroniser for the CPU strobes plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= STROBE_IDLE;
      sync_r <= STROBE_IDLE;
      prev_r <= STROBE_IDLE;
    end else begin
      meta_r <= {nmwr, nmrd, tpb, tpa};
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  // Address capture, pending CPU edges and the bus-cycle sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      addr_hi_r  <= 8'h00;
      addr_lo_r  <= 8'h00;
      rd_pend_r  <= 1'b0;
      wr_pend_r  <= 1'b0;
      acc_we_r   <= 1'b0;
      db_out     <= 8'h00;
      db_oe      <= 1'b0;
      nwait      <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= 8'h00;
`ifdef COSMEM_WAIT_EN
      host_req_prev_r <= 1'b0;
`endif
    end else begin
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      host_ack <= 1'b0;

      if (tpa_fall_s) begin
        addr_hi_r <= ma;
      end
      if (mrd_fall_s || mwr_fall_s) begin
        addr_lo_r <= ma;
      end

`ifdef COSMEM_WAIT_EN
      host_req_prev_r <= host_req;
      if (host_req && !host_req_prev_r && !nmrd_s && !prev_r[2] && rd_open_s) begin
        nwait <= 1'b0;
      end else if (nmrd_s) begin
        nwait <= 1'b1;
      end
`else
      nwait <= 1'b1;
`endif

      // CPU edges arriving while the host owns the RAM are remembered and serviced first from IDLE.
      if (host_busy_s) begin
        if (rd_evt_s) begin
          rd_pend_r <= 1'b1;
`ifdef COSMEM_WAIT_EN
          nwait     <= 1'b0;
`endif
        end else if (wr_evt_s) begin
          wr_pend_r <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          if (rd_go_s) begin
            state_r   <= CPU_RD;
            mem_re    <= 1'b1;
            mem_addr  <= addr_s[ADDR_W-1:0];
            rd_pend_r <= 1'b0;
          end else if (wr_go_s) begin
            state_r   <= CPU_WR_WAIT;
            mem_addr  <= addr_s[ADDR_W-1:0];
            wr_pend_r <= 1'b0;
          end else if (host_req) begin
            state_r   <= HOST_ACC;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
            mem_we    <= host_we;
            mem_re    <= ~host_we;
            acc_we_r  <= host_we;
          end
        end
        CPU_RD: begin
          state_r <= CPU_RD_HOLD;
        end
        CPU_RD_HOLD: begin
          // Level test also covers a /MRD that already rose while the RAM read was in flight.
          if (nmrd_s) begin
            db_oe   <= 1'b0;
            state_r <= IDLE;
          end else if (!db_oe) begin
            db_out <= mem_rdata;
            db_oe  <= 1'b1;
`ifdef COSMEM_WAIT_EN
            nwait  <= 1'b1;
`endif
          end
        end
        CPU_WR_WAIT: begin
          if (tpb_rise_s) begin
            mem_wdata <= db_in;
            state_r   <= CPU_WR;
          end else if (nmwr_s) begin
            state_r <= IDLE;
          end
        end
        CPU_WR: begin
          mem_we  <= 1'b1;
          state_r <= IDLE;
        end
        HOST_ACC: begin
          state_r <= HOST_DONE;
        end
        HOST_DONE: begin
          host_ack <= 1'b1;
          if (!acc_we_r) begin
            host_rdata <= mem_rdata;
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
